// File: rtl/vdc_pkg.sv
// Shared types and register numbers for the VDC host-side access master.
package vdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        POLL,
        POLL_CHK,
        DATA,
        CAP,
        DONE
    } vdc_host_state_t;

    localparam int VDC_REG_UA_HI        = 18;
    localparam int VDC_REG_UA_LO        = 19;
    localparam int VDC_REG_WC           = 30;
    localparam int VDC_REG_DA           = 31;
    localparam int VDC_REG_BA_HI        = 32;
    localparam int VDC_REG_BA_LO        = 33;
    localparam int VDC_NUM_REGS         = 38;
    localparam int VDC_STATUS_READY_BIT = 7;

    // Registers that start a memory transfer and must wait for ready.
    function automatic logic vdc_poll_reg(input logic [5:0] r);
        return (r == 6'(VDC_REG_UA_HI)) ||
               (r == 6'(VDC_REG_UA_LO)) ||
               (r == 6'(VDC_REG_WC))    ||
               (r == 6'(VDC_REG_DA))    ||
               (r == 6'(VDC_REG_BA_HI)) ||
               (r == 6'(VDC_REG_BA_LO));
    endfunction

endpackage

// File: rtl/vdc_host_master_sel.sv
// Tracks which VDC register is currently latched in the address port.
module vdc_host_master_sel
    import vdc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [5:0] load_reg,
    input  logic       acc,
    input  logic [5:0] acc_reg,
    input  logic       tmo,
    output logic       hit
);

    logic       valid;
    logic [5:0] sel;
    logic       out_of_file;

    assign out_of_file = (acc_reg >= 6'(VDC_NUM_REGS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            sel   <= 6'd0;
        end else if (tmo || (acc && out_of_file)) begin
            valid <= 1'b0;
        end else if (load && (load_reg < 6'(VDC_NUM_REGS))) begin
            valid <= 1'b1;
            sel   <= load_reg;
        end
    end

    assign hit = valid && (sel == acc_reg);

endmodule

// File: rtl/vdc_host_master.sv
// Runs one select/poll/data access on the VDC indirect register port.
module vdc_host_master
    import vdc_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 4095,
    parameter bit          POLL_ALL     = 1'b0,
    parameter bit          CACHE_SEL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bus_en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [5:0] req_reg,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       vdc_cs,
    output logic       vdc_rs,
    output logic       vdc_we,
    output logic [7:0] vdc_dout,
    input  logic [7:0] vdc_din
);

    localparam logic [15:0] TMO = 16'(POLL_TIMEOUT);

    vdc_host_state_t state, state_nxt;

    logic        we_q;
    logic [5:0]  reg_q;
    logic [7:0]  data_q;
    logic [15:0] poll_cnt;

    logic        accept;
    logic        hit;
    logic        tmo;
    logic        ready_bit;
    logic        addr_done;
    logic        we_e;
    logic [5:0]  reg_e;
    logic [7:0]  data_e;

    logic        cs_n;
    logic        rs_n;
    logic        we_n;
    logic [7:0]  dout_n;
    logic        ready_n;
    logic        valid_n;
    logic        err_n;
    logic [7:0]  rdata_n;

    function automatic logic poll_needed(input logic [5:0] r);
        return POLL_ALL || vdc_poll_reg(r);
    endfunction

    assign accept    = req_valid && req_ready;
    assign ready_bit = vdc_din[VDC_STATUS_READY_BIT];
    assign addr_done = (state == ADDR) && bus_en;
    assign tmo       = (state == POLL_CHK) && !ready_bit &&
                       (poll_cnt == TMO);

    // Effective request fields, valid on the accepting clk too.
    assign we_e   = accept ? req_we   : we_q;
    assign reg_e  = accept ? req_reg  : reg_q;
    assign data_e = accept ? req_data : data_q;

    vdc_host_master_sel u_sel (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (addr_done),
        .load_reg (reg_q),
        .acc      (accept),
        .acc_reg  (req_reg),
        .tmo      (tmo),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            reg_q     <= 6'd0;
            data_q    <= 8'h00;
            poll_cnt  <= 16'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            vdc_cs    <= 1'b0;
            vdc_rs    <= 1'b0;
            vdc_we    <= 1'b0;
            vdc_dout  <= 8'h00;
        end else begin
            state  <= state_nxt;
            we_q   <= we_e;
            reg_q  <= reg_e;
            data_q <= data_e;
            if (state == DONE) begin
                poll_cnt <= 16'd0;
            end else if ((state == POLL_CHK) && !ready_bit &&
                         (poll_cnt != TMO)) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            req_ready <= ready_n;
            rsp_valid <= valid_n;
            rsp_data  <= rdata_n;
            rsp_err   <= err_n;
            vdc_cs    <= cs_n;
            vdc_rs    <= rs_n;
            vdc_we    <= we_n;
            vdc_dout  <= dout_n;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (CACHE_SEL && hit) begin
                        state_nxt = poll_needed(req_reg) ? POLL : DATA;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                if (bus_en) begin
                    state_nxt = poll_needed(reg_q) ? POLL : DATA;
                end
            end
            POLL: begin
                if (bus_en) begin
                    state_nxt = POLL_CHK;
                end
            end
            POLL_CHK: begin
                if (ready_bit) begin
                    state_nxt = DATA;
                end else if (poll_cnt == TMO) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = POLL;
                end
            end
            DATA: begin
                if (bus_en) begin
                    state_nxt = we_q ? DONE : CAP;
                end
            end
            CAP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        cs_n    = 1'b0;
        rs_n    = 1'b0;
        we_n    = 1'b0;
        dout_n  = 8'h00;
        ready_n = 1'b0;
        valid_n = 1'b0;
        err_n   = rsp_err;
        rdata_n = rsp_data;
        unique case (state_nxt)
            IDLE: ready_n = 1'b1;
            ADDR: begin
                cs_n   = 1'b1;
                we_n   = 1'b1;
                dout_n = {2'b00, reg_e};
            end
            POLL, POLL_CHK: cs_n = 1'b1;
            DATA: begin
                cs_n   = 1'b1;
                rs_n   = 1'b1;
                we_n   = we_e;
                dout_n = we_e ? data_e : 8'h00;
            end
            CAP: ;
            DONE: begin
                valid_n = 1'b1;
                err_n   = tmo;
                rdata_n = (state == CAP) ? vdc_din : 8'h00;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/vdc_host_master.md
Name: vdc_host_master

Overview:
- Hardware initiator for the VDC's two-address indirect register port (address/status register, data register).
- Executes the full CPU-side access protocol for a single register request: latch the register number, poll status bit 7 until ready, then perform the data read or write.
- Lets boot-time register loaders, OSD/debug logic and test harnesses program the VDC without a 6502 in the loop.
- Sits between a simple valid/ready request channel and the VDC cs/rs/we/db pins.

Parameters:
- POLL_TIMEOUT, 4095: maximum status polls before the request is aborted with an error; 1..65535.
- POLL_ALL, 0: 1 = poll before every data phase; 0 = poll only for registers 18, 19, 30, 31, 32, 33.
- CACHE_SEL, 1: 1 = skip the address phase when req_reg equals the last register number written and the cache is valid.

Ports:
- clk  in  1  system clock (same clock as the VDC).
- reset_n  in  1  asynchronous, active-low reset.
- bus_en  in  1  CPU bus strobe (the VDC enableBus); a bus phase completes on a clk where bus_en=1.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_reg  in  6  VDC register number 0..63.
- req_data  in  8  write data.
- rsp_valid  out  1  one-clk pulse at completion.
- rsp_data  out  8  read data (write: 8'h00); held until the next rsp_valid.
- rsp_err  out  1  qualifies rsp_valid; set on poll timeout.
- vdc_cs  out  1  chip select.
- vdc_rs  out  1  0 = address/status, 1 = data.
- vdc_we  out  1  write enable.
- vdc_dout  out  8  data to the VDC db_in.
- vdc_din  in  8  data from the VDC db_out.

Behaviour:
- Reset values: clk and reset_n as above; reset is asynchronous and active-low. All outputs are registered. On reset: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, vdc_cs=0, vdc_rs=0, vdc_we=0, vdc_dout=0, sel cache invalid, poll counter 0.
- Bus phase: cs/rs/we/dout are driven from the first clk of the state and held stable. The phase completes on the first clk with bus_en=1; the state advances on the following clk.
- IDLE: on accept, latch we/reg/data and drive nothing.
  - If CACHE_SEL and cache valid and req_reg == cached sel: go to POLL/DATA.
  - Otherwise: go to ADDR.
- ADDR: cs=1, rs=0, we=1, dout={2'b00, reg}. On completion, load the sel cache and set it valid.
- POLL (entered if the poll rule applies, else go straight to DATA): cs=1, rs=0, we=0.
  - On a bus_en clk, go to POLL_CHK.
  - POLL_CHK samples vdc_din (registered by the VDC during the prior clk).
  - Bit 7 = 1: go to DATA.
  - Bit 7 = 0: increment the counter and re-enter POLL with cs held.
  - Counter == POLL_TIMEOUT: go to DONE with rsp_err=1.
- DATA write: cs=1, rs=1, we=1, dout=data. On completion, go to DONE.
- DATA read: cs=1, rs=1, we=0. On the bus_en clk, go to CAP. CAP captures vdc_din into rsp_data (one-clk read latency after the bus_en clk), then goes to DONE. Exactly one bus_en clk with cs&~we&rs is presented, so read side effects (light-pen status clear on R16/R17, R31 auto-increment) happen once.
- DONE: drop cs/we, pulse rsp_valid for 1 clk, clear the poll counter, return to IDLE. req_ready rises on the clk after rsp_valid.
- Sel cache invalidation: reset, timeout error, and any request with req_reg ≥ 38 (outside the register file; the address phase is still issued and the cache is not loaded).
- bus_en held permanently high: each phase takes 1 clk; minimum write latency (cached, no poll) is accept → rsp_valid in 3 clks.
- bus_en never high: the block stalls in its phase indefinitely. There is no timeout outside POLL, by design.
- Reset mid-operation: asynchronous return to the reset state; a partial access leaves the VDC register selected but no data written.
- Requests arriving while busy: ignored, since req_ready=0; the requester must hold req_valid.
- The poll counter is 16 bits and saturates at POLL_TIMEOUT; there is no wrap.

Decomposition:
- Shared package vdc_pkg holds:
  - enum vdc_host_state_t {IDLE, ADDR, POLL, POLL_CHK, DATA, CAP, DONE};
  - localparams VDC_REG_UA_HI=18, VDC_REG_UA_LO=19, VDC_REG_WC=30, VDC_REG_DA=31, VDC_REG_BA_HI=32, VDC_REG_BA_LO=33, VDC_NUM_REGS=38, VDC_STATUS_READY_BIT=7.
- Optional sub-module vdc_host_bootload: ROM-table walker that feeds (reg, data) pairs into this block after reset to load the default register set. It is not part of this block.

Test Plan:
- Cold write, bus_en every 4th clk, req(we=1, reg=26, data=8'hF0) → ADDR writes 8'h1A with rs=0 on a bus_en clk; DATA writes 8'hF0 with rs=1; no poll cycle; rsp_valid with rsp_err=0.
- Cached write: immediately repeat reg=26 with data=8'h0F → no ADDR phase; only a single rs=1 write; with bus_en constant high, rsp_valid arrives 3 clks after accept.
- Polled write to R31 with the VDC model reporting busy for 5 polls → 5 status reads showing bit7=0, then the data write of req_data; exactly one rs=1 bus_en write cycle.
- Read of R16 with lpStatus set in the model → exactly one rs=1 read bus_en clk; rsp_data equals the model's light-pen V value; the model's lpStatus clears once.
- Poll timeout with POLL_TIMEOUT=3 and status bit7 stuck at 0 → exactly 4 status reads, rsp_err=1, no data phase; the next request to the same register reissues ADDR.
- Assert reset_n low while in POLL → vdc_cs drops asynchronously; all outputs return to reset values; the following request to the same register reissues ADDR.
